// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: fixed priority to
// the pipeline port C, with a starvation guard that periodically forces port D.
module dmem_arbiter #(
  parameter int ASIZE        = 16,
  parameter int DSIZE        = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [ASIZE-1:0] c_addr,
  input  logic [DSIZE-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_stall,
  output logic             c_rvalid,
  output logic [DSIZE-1:0] c_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [ASIZE-1:0] d_addr,
  input  logic [DSIZE-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DSIZE-1:0] d_rdata,
  output logic             m_memwrite,
  output logic             m_memread,
  output logic [ASIZE-1:0] m_addr,
  output logic [DSIZE-1:0] m_wdata,
  input  logic [DSIZE-1:0] m_rdata,
  output logic [15:0]      conflict_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       rd_pend;
  logic       rd_owner;  // 0 = C, 1 = D
  logic       rd_grant;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req && starve_cnt == LIMIT) d_gnt = 1'b1;
      else if (c_req)                   c_gnt = 1'b1;
      else if (d_req)                   d_gnt = 1'b1;
    end
  end

  // While rst is held the grant is already low, which also keeps the memory
  // from seeing writes during its own preload.
  assign c_stall    = c_req & ~c_gnt & ~rst;
  assign m_memwrite = (c_gnt & c_we) | (d_gnt & d_we);
  assign m_addr     = c_gnt ? c_addr  : (d_gnt ? d_addr  : '0);
  assign m_wdata    = c_gnt ? c_wdata : (d_gnt ? d_wdata : '0);
  assign rd_grant   = (c_gnt & ~c_we) | (d_gnt & ~d_we);

  // A read granted just before reset would otherwise surface during the first
  // reset cycle; masking with rst drops it.
  assign m_memread = rd_pend & ~rst;
  assign c_rvalid  = m_memread & ~rd_owner;
  assign d_rvalid  = m_memread & rd_owner;
  assign c_rdata   = c_rvalid ? m_rdata : '0;
  assign d_rdata   = d_rvalid ? m_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend      <= 1'b0;
      rd_owner     <= 1'b0;
      starve_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      rd_pend <= rd_grant;
      if (rd_grant) rd_owner <= d_gnt;

      if (d_gnt || !d_req)                 starve_cnt <= '0;
      else if (c_gnt && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;

      if (c_req && d_req && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory, a cycle-level reference model
// of the arbitration rules, directed scenarios and randomized requesters.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [15:0] c_rdata, d_rdata;
  logic        m_memwrite, m_memread;
  logic [15:0] m_addr, m_wdata, m_rdata, conflict_cnt;

  dmem_arbiter #(.ASIZE(16), .DSIZE(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_memwrite(m_memwrite), .m_memread(m_memread), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Single-port memory: synchronous write, registered read address.
  logic [15:0] mem [0:65535];
  logic [15:0] raddr = '0;
  always @(posedge clk) begin
    if (m_memwrite) mem[m_addr] <= m_wdata;
    raddr <= m_addr;
  end
  assign m_rdata = mem[raddr];

  // Reference model state.
  logic [15:0] ref_mem [0:65535];
  int          lost_cnt;
  bit          p_valid, p_owner;
  logic [15:0] p_data;
  int          conf_cnt;

  int checks = 0;
  int errors = 0;

  // Values observed in the last modelled cycle, for directed checks.
  bit          g_c, g_d, s_stall, s_memwrite, s_c_rvalid, s_d_rvalid;
  logic [15:0] s_c_rdata, s_d_rdata, s_conf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; compare at the negedge,
  // advance the model at the posedge, return 1 time unit after it.
  task automatic cycle();
    bit          ec, ed, ewr;
    logic [15:0] ea, ew;
    @(negedge clk);
    ec = 1'b0; ed = 1'b0;
    if (!rst) begin
      if (d_req && lost_cnt >= LIMIT) ed = 1'b1;
      else if (c_req)                 ec = 1'b1;
      else if (d_req)                 ed = 1'b1;
    end
    ewr = (ec && c_we) || (ed && d_we);
    ea  = ec ? c_addr  : (ed ? d_addr  : 16'h0);
    ew  = ec ? c_wdata : (ed ? d_wdata : 16'h0);
    check("c_gnt",     32'(c_gnt),      32'(ec));
    check("d_gnt",     32'(d_gnt),      32'(ed));
    check("c_stall",   32'(c_stall),    32'(!rst && c_req && !ec));
    check("memwrite",  32'(m_memwrite), 32'(ewr));
    check("m_addr",    32'(m_addr),     32'(ea));
    check("m_wdata",   32'(m_wdata),    32'(ew));
    check("memread",   32'(m_memread),  32'(!rst && p_valid));
    check("c_rvalid",  32'(c_rvalid),   32'(!rst && p_valid && !p_owner));
    check("d_rvalid",  32'(d_rvalid),   32'(!rst && p_valid && p_owner));
    check("c_rdata",   32'(c_rdata),    32'((!rst && p_valid && !p_owner) ? p_data : 16'h0));
    check("d_rdata",   32'(d_rdata),    32'((!rst && p_valid && p_owner) ? p_data : 16'h0));
    check("conflict",  32'(conflict_cnt), 32'(conf_cnt));
    g_c = c_gnt; g_d = d_gnt; s_stall = c_stall; s_memwrite = m_memwrite;
    s_c_rvalid = c_rvalid; s_d_rvalid = d_rvalid;
    s_c_rdata = c_rdata; s_d_rdata = d_rdata; s_conf = conflict_cnt;
    @(posedge clk);
    if (rst) begin
      lost_cnt = 0; p_valid = 0; p_owner = 0; conf_cnt = 0;
    end else begin
      if (ewr) ref_mem[ea] = ew;
      p_valid = (ec || ed) && !ewr;
      if (p_valid) begin
        p_owner = ed;
        p_data  = ref_mem[ea];
      end
      if (ed || !d_req)              lost_cnt = 0;
      else if (lost_cnt < LIMIT)     lost_cnt++;
      if (c_req && d_req && conf_cnt < 65535) conf_cnt++;
    end
    #1;
  endtask

  task automatic drive_c(input bit req, input bit we, input logic [15:0] a, input logic [15:0] w);
    c_req = req; c_we = we; c_addr = a; c_wdata = w;
  endtask

  task automatic drive_d(input bit req, input bit we, input logic [15:0] a, input logic [15:0] w);
    d_req = req; d_we = we; d_addr = a; d_wdata = w;
  endtask

  initial begin
    bit          ca, da, cw, dw;
    logic [15:0] caddr, cwd, daddr, dwd;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[5] = 16'hBEEF; ref_mem[5] = 16'hBEEF;
    mem[1] = 16'hAAAA; ref_mem[1] = 16'hAAAA;
    mem[2] = 16'h5555; ref_mem[2] = 16'h5555;
    lost_cnt = 0; p_valid = 0; p_owner = 0; p_data = '0; conf_cnt = 0;

    // Reset with requests asserted: no grants, no writes, everything low.
    rst = 1'b1;
    drive_c(1, 1, 16'h0007, 16'h1111);
    drive_d(1, 1, 16'h0008, 16'h2222);
    @(posedge clk); #1;
    cycle();
    cycle();
    drive_c(0, 0, 0, 0); drive_d(0, 0, 0, 0);
    rst = 1'b0;

    // C read only.
    drive_c(1, 0, 16'h0005, 0); cycle();
    check("t1_gnt", 32'(g_c), 32'd1);
    drive_c(0, 0, 0, 0); cycle();
    check("t1_rvalid", 32'(s_c_rvalid), 32'd1);
    check("t1_rdata", 32'(s_c_rdata), 32'hBEEF);
    check("t1_d_rvalid", 32'(s_d_rvalid), 32'd0);

    // C write then read of the same address.
    drive_c(1, 1, 16'h0010, 16'h1234); cycle();
    check("t2_wr", 32'(s_memwrite), 32'd1);
    drive_c(1, 0, 16'h0010, 0); cycle();
    check("t2_rd_nowr", 32'(s_memwrite), 32'd0);
    drive_c(0, 0, 0, 0); cycle();
    check("t2_rdata", 32'(s_c_rdata), 32'h1234);

    // Contention: D forced through once every LIMIT+1 cycles.
    drive_c(1, 0, 16'h0003, 0); drive_d(1, 0, 16'h0004, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check($sformatf("t3_dgnt%0d", i), 32'(g_d), 32'(i % 5 == 4));
      check($sformatf("t3_stall%0d", i), 32'(s_stall), 32'(i % 5 == 4));
    end
    drive_c(0, 0, 0, 0); drive_d(0, 0, 0, 0); cycle();
    check("t3_conflict", 32'(s_conf), 32'd10);
    cycle();

    // Interleaved C/D reads: never both rvalid in one cycle.
    drive_c(1, 0, 16'h0001, 0); cycle();
    drive_c(0, 0, 0, 0); drive_d(1, 0, 16'h0002, 0); cycle();
    check("t4_c_rvalid", 32'(s_c_rvalid), 32'd1);
    check("t4_c_rdata", 32'(s_c_rdata), 32'hAAAA);
    check("t4_d_rvalid_n1", 32'(s_d_rvalid), 32'd0);
    drive_d(0, 0, 0, 0); cycle();
    check("t4_d_rvalid", 32'(s_d_rvalid), 32'd1);
    check("t4_d_rdata", 32'(s_d_rdata), 32'h5555);
    check("t4_c_rvalid_n2", 32'(s_c_rvalid), 32'd0);

    // Reset with a D read in flight.
    drive_d(1, 0, 16'h0002, 0); cycle();
    check("t5_dgnt", 32'(g_d), 32'd1);
    drive_d(0, 0, 0, 0); rst = 1'b1; cycle();
    check("t5_rvalid_rst", 32'(s_d_rvalid), 32'd0);
    rst = 1'b0; cycle();
    check("t5_rvalid_after", 32'(s_d_rvalid), 32'd0);
    check("t5_conflict", 32'(s_conf), 32'd0);

    // Randomized requesters that hold their request until granted.
    ca = 0; da = 0; cw = 0; dw = 0; caddr = 0; cwd = 0; daddr = 0; dwd = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ca && $urandom_range(1, 0) == 1) begin
        ca = 1; cw = 1'($urandom); caddr = 16'($urandom_range(15, 0)); cwd = 16'($urandom);
      end
      if (!da && $urandom_range(2, 0) == 0) begin
        da = 1; dw = 1'($urandom); daddr = 16'($urandom_range(15, 0)); dwd = 16'($urandom);
      end
      rst = ($urandom_range(199, 0) == 0);
      drive_c(ca, cw, caddr, cwd);
      drive_d(da, dw, daddr, dwd);
      cycle();
      if (g_c) ca = 0;
      if (g_d) da = 0;
    end
    rst = 1'b0;
    drive_c(0, 0, 0, 0); drive_d(0, 0, 0, 0);
    cycle();

    // Saturation of the conflict counter (reads only, memory untouched).
    rst = 1'b1; cycle(); rst = 1'b0;
    drive_c(1, 0, 16'h0001, 0); drive_d(1, 0, 16'h0002, 0);
    repeat (66000) @(posedge clk);
    @(negedge clk);
    check("sat_conflict", 32'(conflict_cnt), 32'hFFFF);
    @(posedge clk); #1;
    drive_c(0, 0, 0, 0); drive_d(0, 0, 0, 0);
    conf_cnt = 65535;
    rst = 1'b1; cycle();
    rst = 1'b0; cycle();
    check("sat_cleared", 32'(s_conf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
